// File: rtl/fifo_fwft.sv
// Synchronous single-clock FIFO with selectable registered or first-word-fall-through read,
// occupancy count, level flags and sticky overflow/underflow flags.
module fifo_fwft #(
    parameter int WIDTH                  = 16,
    parameter int DEPTH                  = 256,
    parameter int ALMOST_FULL_DEPTH_VAL  = 252,
    parameter int ALMOST_EMPTY_DEPTH_VAL = 4,
    parameter bit FWFT                   = 1'b0
) (
    input  logic                           fifo_clk,
    input  logic                           fifo_rst,
    input  logic                           fifo_we,
    input  logic                           fifo_re,
    input  logic                           fifo_flush,
    input  logic                           fifo_clr_err,
    input  logic signed [WIDTH-1:0]        fifo_in,
    output logic signed [WIDTH-1:0]        fifo_out,
    output logic                           fifo_valid,
    output logic [$clog2(DEPTH):0]         fifo_count,
    output logic                           fifo_almost_full,
    output logic                           fifo_full,
    output logic                           fifo_almost_empty,
    output logic                           fifo_empty,
    output logic                           fifo_overflow,
    output logic                           fifo_underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic signed [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]           count;
    logic                    rd_ok, wr_ok, ovf_evt, unf_evt;

    assign fifo_count        = count;
    assign fifo_full         = (count == CW'(DEPTH));
    assign fifo_empty        = (count == '0);
    assign fifo_almost_full  = (count >= CW'(ALMOST_FULL_DEPTH_VAL));
    assign fifo_almost_empty = (count <= CW'(ALMOST_EMPTY_DEPTH_VAL));

    // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside it.
    assign rd_ok   = fifo_re && !fifo_empty && !fifo_flush;
    assign wr_ok   = fifo_we && (!fifo_full || rd_ok) && !fifo_flush;
    assign ovf_evt = fifo_we && fifo_full && !rd_ok && !fifo_flush;
    assign unf_evt = fifo_re && fifo_empty && !fifo_flush;

    // Storage is deliberately not reset.
    always_ff @(posedge fifo_clk) begin
        if (!fifo_rst && wr_ok)
            mem[wr_ptr] <= fifo_in;
    end

    always_ff @(posedge fifo_clk) begin
        if (fifo_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (fifo_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A fresh error wins over a coincident clear.
    always_ff @(posedge fifo_clk) begin
        if (fifo_rst) begin
            fifo_overflow  <= 1'b0;
            fifo_underflow <= 1'b0;
        end else begin
            if (ovf_evt)           fifo_overflow  <= 1'b1;
            else if (fifo_clr_err) fifo_overflow  <= 1'b0;
            if (unf_evt)           fifo_underflow <= 1'b1;
            else if (fifo_clr_err) fifo_underflow <= 1'b0;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign fifo_out   = mem[rd_ptr];
            assign fifo_valid = !fifo_empty;
        end else begin : g_reg
            logic signed [WIDTH-1:0] out_q;
            always_ff @(posedge fifo_clk) begin
                if (fifo_rst)   out_q <= '0;
                else if (rd_ok) out_q <= mem[rd_ptr];
            end
            assign fifo_out   = out_q;
            assign fifo_valid = 1'b0;
        end
    endgenerate
endmodule

// File: tb/tb_fifo_fwft.sv
// Directed bench for fifo_fwft: a registered-read and a FWFT instance share one stimulus stream.
module tb_fifo_fwft;
    logic clk = 1'b0;
    logic rst, we, re, flush, clr;
    logic signed [15:0] din;

    logic signed [15:0] out0, out1;
    logic               vld0, vld1;
    logic [8:0]         cnt0, cnt1;
    logic               af0, f0, ae0, e0, ov0, un0;
    logic               af1, f1, ae1, e1, ov1, un1;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    fifo_fwft #(.FWFT(1'b0)) u_reg (
        .fifo_clk(clk), .fifo_rst(rst), .fifo_we(we), .fifo_re(re),
        .fifo_flush(flush), .fifo_clr_err(clr), .fifo_in(din),
        .fifo_out(out0), .fifo_valid(vld0), .fifo_count(cnt0),
        .fifo_almost_full(af0), .fifo_full(f0), .fifo_almost_empty(ae0),
        .fifo_empty(e0), .fifo_overflow(ov0), .fifo_underflow(un0)
    );

    fifo_fwft #(.FWFT(1'b1)) u_fwft (
        .fifo_clk(clk), .fifo_rst(rst), .fifo_we(we), .fifo_re(re),
        .fifo_flush(flush), .fifo_clr_err(clr), .fifo_in(din),
        .fifo_out(out1), .fifo_valid(vld1), .fifo_count(cnt1),
        .fifo_almost_full(af1), .fifo_full(f1), .fifo_almost_empty(ae1),
        .fifo_empty(e1), .fifo_overflow(ov1), .fifo_underflow(un1)
    );

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // One rising edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 0; re = 0; flush = 0; clr = 0; rst = 0;
    endtask

    task automatic do_reset();
        idle(); rst = 1; step(); rst = 0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_cnt"},  cnt0, 0);
        chk({tag, "_emp"},  e0, 1);
        chk({tag, "_aemp"}, ae0, 1);
        chk({tag, "_full"}, f0, 0);
        chk({tag, "_afull"}, af0, 0);
        chk({tag, "_out"},  out0, 0);
        chk({tag, "_ovf"},  ov0, 0);
        chk({tag, "_unf"},  un0, 0);
        chk({tag, "_vld0"}, vld0, 0);
        chk({tag, "_vld1"}, vld1, 0);
    endtask

    initial begin
        idle(); din = '0;
        #2;
        do_reset();
        chk_reset_state("rst");

        // Registered read: 129, 45
        we = 1; din = 129; step(); chk("r20_cnt1", cnt0, 1);
        din = 45;          step(); chk("r20_cnt2", cnt0, 2);
        we = 0; re = 1;    step(); chk("r20_out129", out0, 129); chk("r20_cnt3", cnt0, 1);
                           step(); chk("r20_out45", out0, 45);   chk("r20_cnt4", cnt0, 0);
        re = 0;

        // FWFT single word -7
        do_reset();
        we = 1; din = -7; step(); we = 0;
        chk("r21_out", out1, -7); chk("r21_vld", vld1, 1);
        chk("r21_regout_hold", out0, 0);
        re = 1; step(); re = 0;
        chk("r21_vld_after", vld1, 0); chk("r21_regout", out0, -7);

        // Underflow on empty and sticky clear
        re = 1; step(); re = 0;
        chk("r24_unf", un0, 1); chk("r24_out_hold", out0, -7); chk("r24_cnt", cnt0, 0);
        step(); chk("r24_sticky", un0, 1);
        clr = 1; step(); clr = 0; chk("r24_clr", un0, 0);
        re = 1; clr = 1; step(); re = 0; clr = 0; chk("r24_err_wins", un0, 1);
        clr = 1; step(); clr = 0; chk("r24_clr2", un0, 0);

        // Empty with we=re=1: write taken, read rejected
        we = 1; re = 1; din = 77; step(); we = 0; re = 0;
        chk("r12_cnt", cnt0, 1); chk("r12_out", out0, -7); chk("r12_fwft", out1, 77);

        // Fill 0..255 and overflow
        do_reset();
        we = 1;
        for (int i = 0; i < 256; i++) begin
            din = 16'(i); step();
            if (i == 3)   chk("r22_ae_at4", ae0, 1);
            if (i == 4)   chk("r22_ae_at5", ae0, 0);
            if (i == 250) chk("r22_af_at251", af0, 0);
            if (i == 251) chk("r22_af_at252", af0, 1);
            if (i == 254) chk("r22_full_at255", f0, 0);
        end
        chk("r22_full", f0, 1); chk("r22_cnt256", cnt0, 256); chk("r22_ovf_pre", ov0, 0);
        din = 999; step(); we = 0;
        chk("r22_ovf", ov0, 1); chk("r22_cnt_stay", cnt0, 256);
        re = 1;
        for (int i = 0; i < 256; i++) begin
            chk("r22_fwft_head", out1, i);
            step();
            chk("r22_rd", out0, i);
        end
        re = 0;
        chk("r22_empty", e0, 1); chk("r22_ovf_sticky", ov0, 1);

        // Full with simultaneous read/write, then drain across the wrap
        do_reset();
        we = 1;
        for (int i = 0; i < 256; i++) begin din = 16'(i); step(); end
        re = 1;
        for (int k = 0; k < 10; k++) begin
            din = 16'(1000 + k); step();
            chk("r23_rd", out0, k); chk("r23_cnt", cnt0, 256);
        end
        we = 0;
        chk("r23_ovf", ov0, 0);
        for (int i = 0; i < 256; i++) begin
            step();
            chk("r23_drain", out0, (i < 246) ? (i + 10) : (1000 + i - 246));
        end
        re = 0;
        chk("r23_empty", e0, 1); chk("r23_unf", un0, 0);

        // Flush at count 100, then reset mid-burst
        do_reset();
        we = 1;
        for (int i = 0; i < 100; i++) begin din = 16'(500 + i); step(); end
        we = 0; re = 1; step(); re = 0;
        chk("r25_out500", out0, 500); chk("r25_cnt99", cnt0, 99);
        we = 1; din = 600; step(); we = 0;
        chk("r25_cnt100", cnt0, 100);
        flush = 1; we = 1; re = 1; din = 1; step(); idle();
        chk("r25_fl_cnt", cnt0, 0); chk("r25_fl_emp", e0, 1);
        chk("r25_fl_out", out0, 500); chk("r25_fl_unf", un0, 0); chk("r25_fl_vld1", vld1, 0);
        we = 1;
        for (int i = 0; i < 100; i++) begin din = 16'(i); step(); end
        chk("r25_cnt_b", cnt0, 100);
        re = 1; step();
        chk("r25_out_b", out0, 0);
        rst = 1; flush = 1; clr = 1; step(); idle();
        chk_reset_state("r25_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
